// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg -- shared definitions for the freq_meter block.
//   fm_state_e : period-measurement FSM states
//   AVG_DEPTH  : number of periods averaged when FREQ_METER_AVG_EN is defined
//   AVG_SHIFT  : log2(AVG_DEPTH), the divide-by-depth shift and group counter width
// -----------------------------------------------------------------------------
package synth_pkg;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,  // waiting for the first rising crossing
    MEASURE = 2'd1,  // counting samples between rising crossings
    STALL   = 2'd2   // counter saturated, timeout asserted
  } fm_state_e;

  localparam int AVG_DEPTH = 4;
  localparam int AVG_SHIFT = $clog2(AVG_DEPTH);

  // Group-counter value at which the last period of an averaging group arrives.
  localparam logic [AVG_SHIFT-1:0] GRP_LAST = AVG_SHIFT'(AVG_DEPTH - 1);

endpackage

// File: rtl/freq_meter_schmitt_trigger.sv
// -----------------------------------------------------------------------------
// schmitt_trigger -- hysteresis comparator on a signed sample stream.
//   main_clk  : clock, rising edge
//   reset_n   : asynchronous active-low reset (level resets HIGH)
//   sample_en : one-cycle strobe qualifying din
//   din       : signed sample
//   hyst      : unsigned hysteresis half-band
//   level     : registered Schmitt level
//   rise      : combinational, high while the current strobed sample will
//               move level LOW->HIGH (lets the consumer act on the same edge)
// -----------------------------------------------------------------------------
module schmitt_trigger #(
  parameter int DIN_WIDTH = 24
) (
  input  logic                        main_clk,
  input  logic                        reset_n,
  input  logic                        sample_en,
  input  logic signed [DIN_WIDTH-1:0] din,
  input  logic        [DIN_WIDTH-2:0] hyst,
  output logic                        level,
  output logic                        rise
);

  // One extra bit so that +hyst and -hyst are both representable alongside din.
  logic signed [DIN_WIDTH:0] w_din_ext;
  logic signed [DIN_WIDTH:0] w_pos_th;
  logic signed [DIN_WIDTH:0] w_neg_th;
  logic                      w_above;
  logic                      w_below;
  logic                      r_level;

  assign w_din_ext = {din[DIN_WIDTH-1], din};
  assign w_pos_th  = {2'b00, hyst};
  assign w_neg_th  = -w_pos_th;
  assign w_above   = (w_din_ext > w_pos_th);
  assign w_below   = (w_din_ext < w_neg_th);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= 1'b1;
    end else if (sample_en) begin
      if (w_above) begin
        r_level <= 1'b1;
      end else if (w_below) begin
        r_level <= 1'b0;
      end
    end
  end

  assign level = r_level;
  assign rise  = sample_en & ~r_level & w_above;

endmodule

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter -- measures the period (in samples) between rising crossings of a
// Schmitt-triggered signed waveform.
//   main_clk     : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   sample_en    : one-cycle strobe marking a valid din
//   din          : signed waveform sample
//   hyst         : hysteresis half-band
//   period       : last measured period, held between updates
//   period_valid : one-cycle pulse when period updates
//   timeout      : high while the counter is saturated with no crossing
// Build option: FREQ_METER_AVG_EN -- report the mean of every 4 periods,
// pulsing period_valid once per group.
// -----------------------------------------------------------------------------
module freq_meter
  import synth_pkg::*;
#(
  parameter int DIN_WIDTH    = 24,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                        main_clk,
  input  logic                        reset_n,
  input  logic                        sample_en,
  input  logic signed [DIN_WIDTH-1:0] din,
  input  logic        [DIN_WIDTH-2:0] hyst,
  output logic     [PERIOD_WIDTH-1:0] period,
  output logic                        period_valid,
  output logic                        timeout
);

  localparam logic [PERIOD_WIDTH-1:0] COUNT_MAX = {PERIOD_WIDTH{1'b1}};
  localparam logic [PERIOD_WIDTH-1:0] COUNT_ONE = PERIOD_WIDTH'(1);

  logic                    w_level;
  logic                    w_rise;

  fm_state_e               r_state,   w_state_nxt;
  logic [PERIOD_WIDTH-1:0] r_count,   w_count_nxt;
  logic [PERIOD_WIDTH-1:0] r_period,  w_period_nxt;
  logic                    r_valid,   w_valid_nxt;
  logic                    r_timeout, w_timeout_nxt;
  logic [PERIOD_WIDTH-1:0] w_count_inc;

`ifdef FREQ_METER_AVG_EN
  logic [PERIOD_WIDTH+AVG_SHIFT-1:0] r_sum, w_sum_nxt, w_sum_add;
  logic [AVG_SHIFT-1:0]              r_grp, w_grp_nxt;

  assign w_sum_add = r_sum + {{AVG_SHIFT{1'b0}}, r_count};
`endif

  schmitt_trigger #(
    .DIN_WIDTH (DIN_WIDTH)
  ) u_schmitt (
    .main_clk  (main_clk),
    .reset_n   (reset_n),
    .sample_en (sample_en),
    .din       (din),
    .hyst      (hyst),
    .level     (w_level),
    .rise      (w_rise)
  );

  assign w_count_inc = r_count + 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_period_nxt  = r_period;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = r_timeout;
`ifdef FREQ_METER_AVG_EN
    w_sum_nxt     = r_sum;
    w_grp_nxt     = r_grp;
`endif
    if (sample_en) begin
      case (r_state)
        SEEK: begin
          if (w_rise) begin
            w_state_nxt = MEASURE;
            w_count_nxt = COUNT_ONE;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            // The crossing sample is sample 1 of the next period.
            w_count_nxt = COUNT_ONE;
`ifdef FREQ_METER_AVG_EN
            if (r_grp == GRP_LAST) begin
              w_period_nxt = w_sum_add[PERIOD_WIDTH+AVG_SHIFT-1:AVG_SHIFT];
              w_valid_nxt  = 1'b1;
              w_sum_nxt    = '0;
              w_grp_nxt    = '0;
            end else begin
              w_sum_nxt    = w_sum_add;
              w_grp_nxt    = r_grp + 1'b1;
            end
`else
            w_period_nxt = r_count;
            w_valid_nxt  = 1'b1;
`endif
          end else begin
            w_count_nxt = w_count_inc;
            if (w_count_inc == COUNT_MAX) begin
              w_state_nxt   = STALL;
              w_timeout_nxt = 1'b1;
`ifdef FREQ_METER_AVG_EN
              w_sum_nxt     = '0;
              w_grp_nxt     = '0;
`endif
            end
          end
        end
        STALL: begin
          // Counter stays saturated until a crossing restarts measurement.
          if (w_rise) begin
            w_state_nxt   = MEASURE;
            w_count_nxt   = COUNT_ONE;
            w_timeout_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = SEEK;
        end
      endcase
    end
  end

  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= SEEK;
      r_count   <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
`ifdef FREQ_METER_AVG_EN
      r_sum     <= '0;
      r_grp     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_period  <= w_period_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
`ifdef FREQ_METER_AVG_EN
      r_sum     <= w_sum_nxt;
      r_grp     <= w_grp_nxt;
`endif
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter -- directed self-checking bench for freq_meter
// (DIN_WIDTH=24, PERIOD_WIDTH=8 so the saturation point is 255 samples).
// -----------------------------------------------------------------------------
module tb_freq_meter;

  localparam int DW = 24;
  localparam int PW = 8;

  logic                 main_clk;
  logic                 reset_n;
  logic                 sample_en;
  logic signed [DW-1:0] din;
  logic        [DW-2:0] hyst;
  logic        [PW-1:0] period;
  logic                 period_valid;
  logic                 timeout;

  int n_checks;
  int n_fail;

  logic          obs_valid;
  logic [PW-1:0] obs_period;
  logic          obs_timeout;
  logic          obs_valid_gap;

  freq_meter #(
    .DIN_WIDTH    (DW),
    .PERIOD_WIDTH (PW)
  ) dut (
    .main_clk     (main_clk),
    .reset_n      (reset_n),
    .sample_en    (sample_en),
    .din          (din),
    .hyst         (hyst),
    .period       (period),
    .period_valid (period_valid),
    .timeout      (timeout)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  // Present one strobed sample, observe 1 ns after the capturing edge, then
  // hold sample_en low for 'gap' cycles (recording period_valid after the first).
  task automatic do_sample(input logic signed [DW-1:0] d, input int gap);
    @(negedge main_clk);
    din       = d;
    sample_en = 1'b1;
    @(posedge main_clk);
    #1;
    obs_valid     = period_valid;
    obs_period    = period;
    obs_timeout   = timeout;
    obs_valid_gap = period_valid;
    for (int g = 0; g < gap; g++) begin
      @(negedge main_clk);
      sample_en = 1'b0;
      @(posedge main_clk);
      #1;
      if (g == 0) obs_valid_gap = period_valid;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge main_clk);
      sample_en = 1'b0;
    end
  endtask

  function automatic logic signed [DW-1:0] sq(input int i);
    return (i < 4) ? 24'sd1000 : -24'sd1000;
  endfunction

  task automatic test_reset;
    reset_n   = 1'b0;
    sample_en = 1'b0;
    din       = '0;
    hyst      = 23'd100;
    repeat (3) @(posedge main_clk);
    #1;
    n_checks++;
    if (period !== 8'd0) begin
      n_fail++; $display("FAIL reset_period: got %0d expected 0", period);
    end
    n_checks++;
    if (period_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", period_valid);
    end
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout);
    end
    @(negedge main_clk);
    reset_n = 1'b1;
  endtask

  // Five 8-sample square cycles from reset: first report at cycle 2 start.
  task automatic test_square;
    logic          exp_v;
    logic [PW-1:0] exp_p;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 8; i++) begin
        do_sample(sq(i), 0);
        exp_v = (c >= 2) && (i == 0);
        exp_p = (c >= 2) ? 8'd8 : 8'd0;
        n_checks++;
        if (obs_valid !== exp_v) begin
          n_fail++; $display("FAIL square_valid c%0d i%0d: got %b expected %b", c, i, obs_valid, exp_v);
        end
        n_checks++;
        if (obs_period !== exp_p) begin
          n_fail++; $display("FAIL square_period c%0d i%0d: got %0d expected %0d", c, i, obs_period, exp_p);
        end
        n_checks++;
        if (obs_timeout !== 1'b0) begin
          n_fail++; $display("FAIL square_timeout c%0d i%0d: got %b expected 0", c, i, obs_timeout);
        end
      end
    end
  endtask

  // Count is 8 after the square wave; 247 in-band samples bring it to 255.
  task automatic test_timeout;
    logic exp_t;
    for (int k = 1; k <= 252; k++) begin
      do_sample((k % 2 == 1) ? 24'sd50 : -24'sd50, 0);
      exp_t = (k >= 247);
      n_checks++;
      if (obs_timeout !== exp_t) begin
        n_fail++; $display("FAIL timeout_level k%0d: got %b expected %b", k, obs_timeout, exp_t);
      end
      n_checks++;
      if (obs_valid !== 1'b0) begin
        n_fail++; $display("FAIL timeout_valid k%0d: got %b expected 0", k, obs_valid);
      end
    end
  endtask

  task automatic test_resume;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 8; i++) begin
        do_sample(sq(i), 0);
        n_checks++;
        if (obs_timeout !== 1'b0) begin
          n_fail++; $display("FAIL resume_timeout c%0d i%0d: got %b expected 0", c, i, obs_timeout);
        end
        n_checks++;
        if (obs_valid !== ((c == 1) && (i == 0))) begin
          n_fail++; $display("FAIL resume_valid c%0d i%0d: got %b expected %b", c, i, obs_valid, (c == 1) && (i == 0));
        end
      end
    end
    n_checks++;
    if (obs_period !== 8'd8) begin
      n_fail++; $display("FAIL resume_period: got %0d expected 8", obs_period);
    end
  endtask

  task automatic test_reset_mid;
    logic exp_v;
    do_sample(sq(0), 0);
    n_checks++;
    if (obs_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", obs_valid);
    end
    do_sample(sq(1), 0);
    @(negedge main_clk);
    sample_en = 1'b0;
    reset_n   = 1'b0;
    #1;
    n_checks++;
    if ({period, period_valid, timeout} !== 10'd0) begin
      n_fail++; $display("FAIL midreset_async: got p=%0d v=%b t=%b expected all 0", period, period_valid, timeout);
    end
    repeat (3) @(posedge main_clk);
    #1;
    n_checks++;
    if ({period, period_valid, timeout} !== 10'd0) begin
      n_fail++; $display("FAIL midreset_hold: got p=%0d v=%b t=%b expected all 0", period, period_valid, timeout);
    end
    @(negedge main_clk);
    reset_n = 1'b1;
    // Finish the interrupted cycle, then two more: report only at cycle 2 start.
    for (int c = 0; c < 3; c++) begin
      for (int i = (c == 0) ? 2 : 0; i < 8; i++) begin
        do_sample(sq(i), 0);
        exp_v = (c == 2) && (i == 0);
        n_checks++;
        if (obs_valid !== exp_v) begin
          n_fail++; $display("FAIL postreset_valid c%0d i%0d: got %b expected %b", c, i, obs_valid, exp_v);
        end
        n_checks++;
        if (obs_period !== ((c == 2) ? 8'd8 : 8'd0)) begin
          n_fail++; $display("FAIL postreset_period c%0d i%0d: got %0d expected %0d", c, i, obs_period, (c == 2) ? 8 : 0);
        end
      end
    end
  endtask

  // Strobe every third cycle: period unchanged, valid is a single-cycle pulse.
  task automatic test_gated;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 8; i++) begin
        do_sample(sq(i), 2);
        n_checks++;
        if (obs_valid !== (i == 0)) begin
          n_fail++; $display("FAIL gated_valid c%0d i%0d: got %b expected %b", c, i, obs_valid, (i == 0));
        end
        if (i == 0) begin
          n_checks++;
          if (obs_period !== 8'd8) begin
            n_fail++; $display("FAIL gated_period c%0d: got %0d expected 8", c, obs_period);
          end
          n_checks++;
          if (obs_valid_gap !== 1'b0) begin
            n_fail++; $display("FAIL gated_pulse_width c%0d: got %b expected 0", c, obs_valid_gap);
          end
        end
      end
    end
  endtask

  // Periods 8, 8, 10, 10 -> one pulse with period 9 at the closing crossing.
  task automatic test_avg;
    int plen [4];
    int pulses;
    plen[0] = 8; plen[1] = 8; plen[2] = 10; plen[3] = 10;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      do_sample(-24'sd1000, 0);
      if (obs_valid) pulses++;
    end
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < plen[p]; i++) begin
        do_sample((i < plen[p] / 2) ? 24'sd1000 : -24'sd1000, 0);
        if (obs_valid) pulses++;
      end
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL avg_early_pulses: got %0d expected 0", pulses);
    end
    do_sample(24'sd1000, 0);
    n_checks++;
    if (obs_valid !== 1'b1) begin
      n_fail++; $display("FAIL avg_valid: got %b expected 1", obs_valid);
    end
    n_checks++;
    if (obs_period !== 8'd9) begin
      n_fail++; $display("FAIL avg_period: got %0d expected 9", obs_period);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
`ifdef FREQ_METER_AVG_EN
    test_avg;
`else
    test_square;
    test_timeout;
    test_resume;
    test_reset_mid;
    test_gated;
`endif
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
